// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: valid/ready ID/EX pipeline register with optional skid entry and perf counters
module id_ex_stage_reg #(
  parameter int XLEN   = 32,
  parameter int PC_W   = 8,
  parameter int CTRL_W = 12,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [XLEN-1:0]   rd1_in,
  input  logic [XLEN-1:0]   rd2_in,
  input  logic [XLEN-1:0]   imm_in,
  input  logic [31:0]       instr_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [PC_W-1:0]   pc_out,
  output logic [XLEN-1:0]   rd1_out,
  output logic [XLEN-1:0]   rd2_out,
  output logic [XLEN-1:0]   imm_out,
  output logic [31:0]       instr_out,
  output logic [4:0]        rs1_out,
  output logic [4:0]        rs2_out,
  output logic [4:0]        rd_out,
  output logic [2:0]        func3_out,
  output logic [6:0]        func7_out,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);
  localparam int P_W = CTRL_W + PC_W + 3 * XLEN + 32;
  logic [P_W-1:0] in_p, s_p, m_p, src_p;
  logic [CTRL_W-1:0] m_ctrl;
  logic m_valid, s_valid, in_fire, out_fire, m_take;
  assign in_p = {ctrl_in, pc_in, rd1_in, rd2_in, imm_in, instr_in};
  assign in_ready = (SKID != 0) ? !s_valid : (!m_valid || out_ready);
  assign in_fire = in_valid && in_ready;
  assign out_valid = m_valid;
  assign out_fire = m_valid && out_ready;
  assign m_take = !m_valid || out_fire;
  assign src_p = s_valid ? s_p : in_p;
  assign {m_ctrl, pc_out, rd1_out, rd2_out, imm_out, instr_out} = m_p;
  assign ctrl_out = m_valid ? m_ctrl : '0;
  // main/skid entries: M refills from S first (FIFO order), fields are sliced on capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid   <= 1'b0;
      s_valid   <= 1'b0;
      m_p       <= '0;
      s_p       <= '0;
      rs1_out   <= '0;
      rs2_out   <= '0;
      rd_out    <= '0;
      func3_out <= '0;
      func7_out <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (m_take) begin
      m_valid <= s_valid || in_fire;
      s_valid <= (SKID != 0) && s_valid && in_fire;
      if (s_valid || in_fire) begin
        m_p       <= src_p;
        rs1_out   <= src_p[19:15];
        rs2_out   <= src_p[24:20];
        rd_out    <= src_p[11:7];
        func3_out <= src_p[14:12];
        func7_out <= src_p[31:25];
      end
      if (s_valid && in_fire) s_p <= in_p;
    end else if (in_fire) begin
      s_valid <= (SKID != 0);
      s_p     <= in_p;
    end
  end
  // saturating stall and flush counters; a stall in a flush cycle is still counted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (m_valid && !out_ready && stall_count != '1) stall_count <= stall_count + 1'b1;
      if (flush && (m_valid || s_valid) && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: scoreboard bench for the ID/EX pipeline register
module tb_id_ex_stage_reg;
  typedef struct packed {
    logic [11:0] ctrl;
    logic [7:0]  pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic reset, flush, in_valid, out_ready;
  logic [11:0] ctrl_in;
  logic [7:0]  pc_in;
  logic [31:0] rd1_in, rd2_in, imm_in, instr_in;
  logic in_ready, out_valid;
  logic [11:0] ctrl_out;
  logic [7:0]  pc_out;
  logic [31:0] rd1_out, rd2_out, imm_out, instr_out;
  logic [4:0]  rs1_out, rs2_out, rd_out;
  logic [2:0]  func3_out;
  logic [6:0]  func7_out;
  logic [15:0] stall_count, flush_count;

  logic s_in_ready, s_out_valid;
  logic [11:0] s_ctrl;
  logic [7:0]  s_pc;
  logic [31:0] s_rd1, s_rd2, s_imm, s_instr;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [2:0]  s_f3;
  logic [6:0]  s_f7;
  logic [3:0]  s_stall, s_flush;

  logic n_in_ready, n_out_valid;
  logic [11:0] n_ctrl;
  logic [7:0]  n_pc;
  logic [31:0] n_rd1, n_rd2, n_imm, n_instr;
  logic [4:0]  n_rs1, n_rs2, n_rd;
  logic [2:0]  n_f3;
  logic [6:0]  n_f7;
  logic [15:0] n_stall, n_flush;

  ent_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  int pops = 0;
  logic [31:0] instrs [8] = '{32'h00A58533, 32'hFE010113, 32'h00112E23, 32'h0000006F,
                              32'h40B50533, 32'h00C5A023, 32'hFFF00093, 32'h02B50663};

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .pc_in(pc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .instr_in(instr_in), .out_valid(out_valid), .out_ready(out_ready), .ctrl_out(ctrl_out),
    .pc_out(pc_out), .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out),
    .instr_out(instr_out), .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
    .func3_out(func3_out), .func7_out(func7_out), .stall_count(stall_count),
    .flush_count(flush_count));

  id_ex_stage_reg #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .ctrl_in(ctrl_in), .pc_in(pc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .instr_in(instr_in), .out_valid(s_out_valid), .out_ready(out_ready), .ctrl_out(s_ctrl),
    .pc_out(s_pc), .rd1_out(s_rd1), .rd2_out(s_rd2), .imm_out(s_imm),
    .instr_out(s_instr), .rs1_out(s_rs1), .rs2_out(s_rs2), .rd_out(s_rd),
    .func3_out(s_f3), .func7_out(s_f7), .stall_count(s_stall), .flush_count(s_flush));

  id_ex_stage_reg #(.SKID(0)) u_ns (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(n_in_ready),
    .ctrl_in(ctrl_in), .pc_in(pc_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
    .instr_in(instr_in), .out_valid(n_out_valid), .out_ready(out_ready), .ctrl_out(n_ctrl),
    .pc_out(n_pc), .rd1_out(n_rd1), .rd2_out(n_rd2), .imm_out(n_imm),
    .instr_out(n_instr), .rs1_out(n_rs1), .rs2_out(n_rs2), .rd_out(n_rd),
    .func3_out(n_f3), .func7_out(n_f7), .stall_count(n_stall), .flush_count(n_flush));

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [11:0] c, input logic [7:0] p, input logic [31:0] ins);
    ctrl_in  = c;
    pc_in    = p;
    rd1_in   = {24'h0, p} ^ 32'hA5A5_0000;
    rd2_in   = ~({24'h0, p} ^ 32'hA5A5_0000);
    imm_in   = {p, p, p, p};
    instr_in = ins;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [11:0] c, input logic [7:0] p, input logic [31:0] ins);
    int k;
    drive(c, p, ins);
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: pc %0d never accepted", p);
    end else if (!flush) begin
      q.push_back('{ctrl_in, pc_in, rd1_in, rd2_in, imm_in, instr_in});
    end
    @(posedge clk);
    #1;
  endtask

  // monitor: pop and compare on every completed output transfer
  always @(negedge clk) begin
    ent_t e;
    if (!reset) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_output", {1'b1, pc_out}, 9'h0);
        else begin
          e = q.pop_front();
          pops++;
          chk("scoreboard_entry",
              {ctrl_out, pc_out, rd1_out, rd2_out, imm_out, instr_out,
               func7_out, rs2_out, rs1_out, func3_out, rd_out},
              {e.ctrl, e.pc, e.rd1, e.rd2, e.imm, e.instr,
               e.instr[31:25], e.instr[24:20], e.instr[19:15], e.instr[14:12], e.instr[11:7]});
        end
      end
      if (flush) q.delete();
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ctrl_in = '0; pc_in = '0; rd1_in = '0; rd2_in = '0; imm_in = '0; instr_in = '0;
    #1 reset = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_ctrl_out", ctrl_out, 0);
    chk("reset_pc_instr", {pc_out, instr_out}, 0);
    chk("reset_counters", {stall_count, flush_count}, 0);
    chk("reset_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    tick();
    chk("post_reset_in_ready", in_ready, 1);
    out_ready = 1'b1;
    // single add x10,x11,x10
    send(12'h0A5, 8'd0, 32'h00A58533);
    in_valid = 1'b0;
    chk("add_out_valid", out_valid, 1);
    chk("add_ctrl_out", ctrl_out, 12'h0A5);
    chk("add_rs1_rs2_rd", {rs1_out, rs2_out, rd_out}, {5'd11, 5'd10, 5'd10});
    chk("add_func3_func7", {func3_out, func7_out}, 0);
    tick();
    // eight back-to-back entries
    for (int i = 0; i < 8; i++) send(12'h100 + 12'(i), 8'(i), instrs[i]);
    in_valid = 1'b0;
    tick();
    chk("stream_pops", pops, 9);
    chk("stream_stall_count", stall_count, 0);
    // stall with A in M, B in S, C held upstream
    out_ready = 1'b0;
    send(12'h0AA, 8'd8, instrs[1]);
    send(12'h0BB, 8'd9, instrs[4]);
    drive(12'h0CC, 8'd10, instrs[6]);
    tick();
    tick();
    chk("stall_count_3", stall_count, 3);
    chk("full_in_ready", in_ready, 0);
    chk("full_head_pc", {out_valid, pc_out}, {1'b1, 8'd8});
    chk("noskid_in_ready_blocked", n_in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("noskid_in_ready_pass", n_in_ready, 1);
    send(12'h0CC, 8'd10, instrs[6]);
    in_valid = 1'b0;
    tick();
    chk("abc_pops", pops, 12);
    // fill M and S, then flush
    out_ready = 1'b0;
    send(12'h0DD, 8'd11, instrs[2]);
    send(12'h0EE, 8'd12, instrs[5]);
    in_valid = 1'b0;
    chk("both_full_in_ready", in_ready, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_ctrl_out", ctrl_out, 0);
    chk("flush_in_ready", in_ready, 1);
    chk("flush_count_1", flush_count, 1);
    chk("flush_stall_counted", stall_count, 5);
    chk("flush_data_held", pc_out, 11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("empty_flush_not_counted", flush_count, 1);
    // counter saturation
    send(12'h0FF, 8'd13, instrs[3]);
    in_valid = 1'b0;
    repeat (20) tick();
    chk("stall_count_25", stall_count, 25);
    chk("sat_stall_15", s_stall, 15);
    out_ready = 1'b1;
    tick();
    chk("sat_pops", pops, 13);
    // asynchronous reset mid-stream
    out_ready = 1'b0;
    send(12'h011, 8'd14, instrs[7]);
    send(12'h022, 8'd15, instrs[0]);
    drive(12'h033, 8'd16, instrs[1]);
    #3 reset = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_ctrl_out", ctrl_out, 0);
    chk("async_data", {pc_out, instr_out, rd1_out, imm_out}, 0);
    chk("async_fields", {rs1_out, rs2_out, rd_out, func3_out, func7_out}, 0);
    chk("async_counters", {stall_count, flush_count}, 0);
    chk("async_in_ready", in_ready, 1);
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("final_queue_empty", q.size(), 0);
    chk("final_pops", pops, 13);
    chk("final_out_valid", out_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Parametrised ID/EX pipeline register, next generation of the fixed decode-to-execute latch.
- Replaces the global stop/flush inputs with a valid/ready handshake on both sides, backed by an optional one-entry skid buffer, so the ready signal does not ripple back combinationally.
- Extracts rs1/rs2/rd/func3/func7 from the captured instruction.
- Provides saturating stall and flush counters for performance debug.
- Sits between the decoder/register file and the ALU/forwarding unit.

Parameters:
- XLEN, 32, width of register operands and immediate.
- PC_W, 8, program-counter width.
- CTRL_W, 12, width of the packed control bundle (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch, JalrSel, RWSel).
- SKID, 1, 1 = two-entry (main + skid) registered ready; 0 = single entry with combinational ready.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous kill of all held entries (branch taken / exception).
- in_valid  in  1  decode stage offers an entry.
- in_ready  out  1  this block accepts an entry this cycle.
- ctrl_in  in  CTRL_W  packed control bundle.
- pc_in  in  PC_W  PC of the instruction.
- rd1_in  in  XLEN  register file read data 1.
- rd2_in  in  XLEN  register file read data 2.
- imm_in  in  XLEN  sign-extended immediate.
- instr_in  in  32  raw instruction word.
- out_valid  out  1  main entry holds a live instruction.
- out_ready  in  1  execute stage consumes the entry.
- ctrl_out  out  CTRL_W  control; forced to 0 whenever out_valid=0.
- pc_out  out  PC_W  captured PC.
- rd1_out  out  XLEN  captured rd1.
- rd2_out  out  XLEN  captured rd2.
- imm_out  out  XLEN  captured immediate.
- instr_out  out  32  captured instruction.
- rs1_out  out  5  instr[19:15].
- rs2_out  out  5  instr[24:20].
- rd_out  out  5  instr[11:7].
- func3_out  out  3  instr[14:12].
- func7_out  out  7  instr[31:25].
- stall_count  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- flush_count  out  CNT_W  flushes that discarded at least one valid entry.

Behaviour:
- Reset (reset=0, asynchronous):
  - M_valid=0, S_valid=0.
  - All data/field registers = 0.
  - Both counters = 0.
  - in_ready=1 after reset release.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. out_valid = M_valid.
- The rs/rd/func fields are sliced from instr at capture time and registered alongside it. No combinational path runs from instr_in to the field outputs.
- SKID=1:
  - in_ready = !S_valid (registered only).
  - If !M_valid or out_fire:
    - If S_valid: M <- S, S_valid <- 0; if in_fire in the same cycle, S <- input and S_valid <- 1.
    - Otherwise: M <- input and M_valid <- in_fire.
  - Otherwise (M held): if in_fire, S <- input and S_valid <- 1.
  - Ordering is strictly FIFO. No entry is lost or duplicated.
- SKID=0:
  - No S register.
  - in_ready = !M_valid | out_ready.
  - M loads on in_fire; M_valid <- in_fire when !M_valid | out_fire.
- flush=1 (synchronous, highest priority):
  - M_valid <- 0, S_valid <- 0, and an in_fire that cycle is discarded.
  - Data registers hold their values; ctrl_out reads 0 through the valid gating.
  - in_ready=1 the following cycle.
  - An out_fire in the flush cycle is still a completed transfer; the consumer samples it.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Throughput is 1 entry/cycle while out_ready=1.
- Full condition (SKID=1): M_valid & S_valid → in_ready=0. Upstream must hold its inputs stable.
- stall_count: +1 on each cycle with out_valid & !out_ready; saturates at all-ones (no wrap).
- flush_count: +1 when flush & (M_valid | S_valid); saturates at all-ones.
- Flush and a stall in the same cycle: the stall is counted, then the entries are killed.

Test Plan:
- Reset release, then in_valid=1 with instr=0x00A58533 (add x10,x11,x10), ctrl=0x0A5 → next cycle out_valid=1, rs1=11, rs2=10, rd=10, func3=0, func7=0, ctrl_out=0x0A5.
- Stream 8 entries back-to-back with out_ready=1 → 8 consecutive out_valid cycles, PCs 0..7 in order, stall_count=0.
- SKID=1, out_ready=0 for 3 cycles while offering A, B, C → A held in M, B in S, in_ready=0, C held upstream; stall_count=3; on out_ready=1, the order out is A, B, C with no gaps after the first.
- M and S both full, then flush=1 → next cycle out_valid=0, ctrl_out=0, in_ready=1, flush_count=1; a second flush while empty leaves flush_count=1.
- Assert reset=0 mid-stream, asynchronously between clock edges → all outputs 0 immediately, without waiting for a clock edge; counters cleared.
- CNT_W=4, hold out_ready=0 for 20 cycles → stall_count saturates at 15 and does not wrap.
